// File: rtl/clock_time_setter.sv
// Front-panel time-setting controller for the 24-hour clock.
// Three active-low pushbuttons are synchronized and debounced, then drive a
// small edit FSM (hours, then minutes) that finishes with a one-cycle
// parallel-load strobe towards the hour/minute/second counters.

// Per-button conditioning: 2-FF synchronizer, stability counter, and a
// one-cycle press pulse on the debounced falling edge.
module clock_time_setter_debounce #(
  parameter int DEBOUNCE_CYCLES = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Counter runs only while the synchronized level disagrees with the
  // debounced level; any agreement restarts the stability window.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_MAX) deb_d = ~deb_q;
      else                  cnt_d = cnt_q + CW'(1);
    end
    // Only the press (1 -> 0) edge is an event; releases are silent.
    press_d = deb_q & ~deb_d;
  end

  // Synchronizer, debounce state and press pulse; released state on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// Top level: button conditioning plus edit state machine.
module clock_time_setter #(
  parameter int DEBOUNCE_CYCLES = 19,
  parameter int BLINK_CYCLES    = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode_n,
  input  logic       btn_inc_n,
  input  logic       btn_dec_n,
  input  logic [5:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic       load,
  output logic [5:0] load_hours,
  output logic [5:0] load_minutes,
  output logic [5:0] load_seconds,
  output logic [1:0] edit_field,
  output logic       blink
);

  localparam int NUM_BTN = 3;
  localparam int BW = (BLINK_CYCLES > 0) ? $clog2(BLINK_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES);

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_EDIT_HOUR = 2'd1,
    S_EDIT_MIN  = 2'd2,
    S_COMMIT    = 2'd3
  } state_t;

  // Button order in the packed vectors: [0] mode, [1] inc, [2] dec.
  logic [NUM_BTN-1:0] btn_n;
  logic [NUM_BTN-1:0] press;
  logic               ev_mode, ev_inc, ev_dec;

  assign btn_n = {btn_dec_n, btn_inc_n, btn_mode_n};

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_btn
      clock_time_setter_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk  (clk),
        .rst  (rst),
        .btn_n(btn_n[g]),
        .press(press[g])
      );
    end
  endgenerate

  assign ev_mode = press[0];
  assign ev_inc  = press[1];
  assign ev_dec  = press[2];

  state_t        state_q, state_d;
  logic [5:0]    hours_q, hours_d;
  logic [5:0]    minutes_q, minutes_d;
  logic          load_q, load_d;
  logic [1:0]    field_q, field_d;
  logic          blink_q, blink_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          adjust;
  logic [5:0]    hr_inc, hr_dec, mn_inc, mn_dec;

  // Wrap-around neighbours of the working values.
  always_comb begin
    hr_inc = (hours_q   == 6'd23) ? 6'd0  : hours_q   + 6'd1;
    hr_dec = (hours_q   == 6'd0)  ? 6'd23 : hours_q   - 6'd1;
    mn_inc = (minutes_q == 6'd59) ? 6'd0  : minutes_q + 6'd1;
    mn_dec = (minutes_q == 6'd0)  ? 6'd59 : minutes_q - 6'd1;
  end

  // Edit FSM next state and working values. Mode takes priority over
  // inc/dec, and inc with dec in the same cycle cancels out.
  always_comb begin
    state_d   = state_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    load_d    = 1'b0;
    adjust    = 1'b0;
    case (state_q)
      S_RUN: begin
        if (ev_mode) begin
          state_d   = S_EDIT_HOUR;
          hours_d   = cur_hours;
          minutes_d = cur_minutes;
        end
      end
      S_EDIT_HOUR: begin
        if (ev_mode) begin
          state_d = S_EDIT_MIN;
        end else if (ev_inc ^ ev_dec) begin
          adjust  = 1'b1;
          hours_d = ev_inc ? hr_inc : hr_dec;
        end
      end
      S_EDIT_MIN: begin
        if (ev_mode) begin
          state_d = S_COMMIT;
          load_d  = 1'b1;
        end else if (ev_inc ^ ev_dec) begin
          adjust    = 1'b1;
          minutes_d = ev_inc ? mn_inc : mn_dec;
        end
      end
      S_COMMIT: begin
        // Events landing here are intentionally dropped.
        state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Registered display outputs derived from the next state.
  always_comb begin
    case (state_d)
      S_EDIT_HOUR: field_d = 2'b01;
      S_EDIT_MIN:  field_d = 2'b10;
      default:     field_d = 2'b00;
    endcase
    // Blink restarts dark on any state change or edit so the new digits
    // are visible immediately; it only runs inside the edit states.
    blink_d = blink_q;
    bcnt_d  = bcnt_q;
    if ((state_d != state_q) || adjust ||
        !((state_d == S_EDIT_HOUR) || (state_d == S_EDIT_MIN))) begin
      blink_d = 1'b0;
      bcnt_d  = '0;
    end else if (bcnt_q == BLINK_MAX) begin
      blink_d = ~blink_q;
      bcnt_d  = '0;
    end else begin
      bcnt_d = bcnt_q + BW'(1);
    end
  end

  // FSM state, working registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_RUN;
      hours_q   <= 6'd0;
      minutes_q <= 6'd0;
      load_q    <= 1'b0;
      field_q   <= 2'b00;
      blink_q   <= 1'b0;
      bcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      load_q    <= load_d;
      field_q   <= field_d;
      blink_q   <= blink_d;
      bcnt_q    <= bcnt_d;
    end
  end

  assign load         = load_q;
  assign load_hours   = hours_q;
  assign load_minutes = minutes_q;
  assign load_seconds = 6'd0;
  assign edit_field   = field_q;
  assign blink        = blink_q;

endmodule

// File: tb/tb_clock_time_setter.sv
// Bench for clock_time_setter: directed front-panel sessions followed by
// random button activity, every cycle compared with a behavioural model.
module tb_clock_time_setter;

  localparam int DB = 3;
  localparam int BL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode_n, btn_inc_n, btn_dec_n;
  logic [5:0] cur_hours, cur_minutes;
  logic       load;
  logic [5:0] load_hours, load_minutes, load_seconds;
  logic [1:0] edit_field;
  logic       blink;

  clock_time_setter #(.DEBOUNCE_CYCLES(DB), .BLINK_CYCLES(BL)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_mode_n  (btn_mode_n),
    .btn_inc_n   (btn_inc_n),
    .btn_dec_n   (btn_dec_n),
    .cur_hours   (cur_hours),
    .cur_minutes (cur_minutes),
    .load        (load),
    .load_hours  (load_hours),
    .load_minutes(load_minutes),
    .load_seconds(load_seconds),
    .edit_field  (edit_field),
    .blink       (blink)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nloads = 0;
  int last_lh = 0, last_lm = 0, last_ls = 0;

  // Model state: mode 0 run, 1 hours, 2 minutes, 3 commit.
  int m_st, m_h, m_m, m_age;
  bit m_load;
  bit hist [3][8];   // raw button level seen at each of the last 8 edges
  bit deb  [3];
  bit ev   [3];

  task automatic model_reset();
    m_st = 0; m_h = 0; m_m = 0; m_age = 0; m_load = 0;
    for (int b = 0; b < 3; b++) begin
      deb[b] = 1; ev[b] = 0;
      for (int a = 0; a < 8; a++) hist[b][a] = 1;
    end
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_step();
    bit evm, evi, evd, edited, all;
    bit raw [3];
    int prev;
    evm = ev[0]; evi = ev[1]; evd = ev[2];
    edited = 0; prev = m_st; m_load = 0;
    case (m_st)
      0: if (evm) begin m_st = 1; m_h = int'(cur_hours); m_m = int'(cur_minutes); end
      1: if (evm) m_st = 2;
         else if (evi != evd) begin edited = 1; m_h = evi ? (m_h + 1) % 24 : (m_h + 23) % 24; end
      2: if (evm) begin m_st = 3; m_load = 1; end
         else if (evi != evd) begin edited = 1; m_m = evi ? (m_m + 1) % 60 : (m_m + 59) % 60; end
      default: m_st = 0;
    endcase
    if (m_st != prev || edited || m_st == 0 || m_st == 3) m_age = 0;
    else m_age++;
    // A press registers once the synchronized level (two edges old) has
    // disagreed with the debounced level for DB+1 consecutive edges.
    raw[0] = btn_mode_n; raw[1] = btn_inc_n; raw[2] = btn_dec_n;
    for (int b = 0; b < 3; b++) begin
      for (int a = 7; a > 0; a--) hist[b][a] = hist[b][a-1];
      hist[b][0] = raw[b];
      all = 1;
      for (int a = 2; a <= 2 + DB; a++) if (hist[b][a] == deb[b]) all = 0;
      ev[b] = all && deb[b];
      if (all) deb[b] = !deb[b];
    end
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("load", {7'd0, load}, {7'd0, m_load});
    chk("load_hours", {2'd0, load_hours}, 8'(m_h));
    chk("load_minutes", {2'd0, load_minutes}, 8'(m_m));
    chk("load_seconds", {2'd0, load_seconds}, 8'd0);
    chk("edit_field", {6'd0, edit_field}, (m_st == 1) ? 8'd1 : (m_st == 2) ? 8'd2 : 8'd0);
    chk("blink", {7'd0, blink}, ((m_st == 1 || m_st == 2) && ((m_age / (BL + 1)) % 2 == 1)) ? 8'd1 : 8'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
    if (load === 1'b1) begin
      nloads++;
      last_lh = int'(load_hours); last_lm = int'(load_minutes); last_ls = int'(load_seconds);
    end
  endtask

  task automatic press(bit m, bit i, bit d, int hold);
    btn_mode_n = !m; btn_inc_n = !i; btn_dec_n = !d;
    repeat (hold) cycle();
    btn_mode_n = 1; btn_inc_n = 1; btn_dec_n = 1;
    repeat (8) cycle();
  endtask

  task automatic reset_pulse();
    rst = 0;
    #1;
    model_reset();
    chk("rst_load", {7'd0, load}, 8'd0);
    chk("rst_field", {6'd0, edit_field}, 8'd0);
    chk("rst_hours", {2'd0, load_hours}, 8'd0);
    chk("rst_minutes", {2'd0, load_minutes}, 8'd0);
    chk("rst_blink", {7'd0, blink}, 8'd0);
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    int n0, hold, r;
    rst = 0; btn_mode_n = 1; btn_inc_n = 1; btn_dec_n = 1;
    cur_hours = 6'd14; cur_minutes = 6'd37;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_load", {7'd0, load}, 8'd0);
    chk("reset_field", {6'd0, edit_field}, 8'd0);
    chk("reset_hours", {2'd0, load_hours}, 8'd0);
    chk("reset_minutes", {2'd0, load_minutes}, 8'd0);
    chk("reset_seconds", {2'd0, load_seconds}, 8'd0);
    chk("reset_blink", {7'd0, blink}, 8'd0);
    rst = 1;
    repeat (3) cycle();

    // Two-clock glitch on mode is filtered out.
    press(1, 0, 0, 2);
    chk("glitch_field", {6'd0, edit_field}, 8'd0);

    // Hold mode: one event only, snapshot of 14:37.
    btn_mode_n = 0;
    repeat (10) cycle();
    chk("enter_field", {6'd0, edit_field}, 8'd1);
    chk("snap_hours", {2'd0, load_hours}, 8'd14);
    chk("snap_minutes", {2'd0, load_minutes}, 8'd37);
    repeat (50) cycle();
    chk("hold_field", {6'd0, edit_field}, 8'd1);
    btn_mode_n = 1;
    repeat (8) cycle();
    press(1, 0, 0, 6);
    chk("to_min_field", {6'd0, edit_field}, 8'd2);

    // Reset mid-edit abandons the edit without a load.
    n0 = nloads;
    reset_pulse();
    repeat (12) cycle();
    chk("rst_no_load", 8'(nloads - n0), 8'd0);
    chk("rst_run_field", {6'd0, edit_field}, 8'd0);

    // Wrap-around session starting from 23:00.
    cur_hours = 6'd23; cur_minutes = 6'd0;
    press(1, 0, 0, 6);
    chk("b_hours", {2'd0, load_hours}, 8'd23);
    press(0, 1, 0, 6);
    chk("inc_wrap_hours", {2'd0, load_hours}, 8'd0);
    press(0, 0, 1, 6);
    chk("dec_wrap_hours", {2'd0, load_hours}, 8'd23);
    press(0, 1, 1, 6);
    chk("incdec_hours", {2'd0, load_hours}, 8'd23);
    press(1, 0, 0, 6);
    chk("b_min_field", {6'd0, edit_field}, 8'd2);
    press(0, 0, 1, 6);
    chk("dec_wrap_min", {2'd0, load_minutes}, 8'd59);
    n0 = nloads;
    press(1, 0, 0, 6);
    chk("commit_count", 8'(nloads - n0), 8'd1);
    chk("commit_hours", 8'(last_lh), 8'd23);
    chk("commit_minutes", 8'(last_lm), 8'd59);
    chk("commit_seconds", 8'(last_ls), 8'd0);
    repeat (10) cycle();
    chk("after_commit_field", {6'd0, edit_field}, 8'd0);
    chk("after_commit_blink", {7'd0, blink}, 8'd0);
    chk("after_commit_loads", 8'(nloads - n0), 8'd1);

    // Mode and inc together in EDIT_MIN: commit with minutes unchanged.
    cur_hours = 6'd5; cur_minutes = 6'd12;
    press(1, 0, 0, 6);
    press(1, 0, 0, 6);
    n0 = nloads;
    press(1, 1, 0, 6);
    chk("modeinc_count", 8'(nloads - n0), 8'd1);
    chk("modeinc_minutes", 8'(last_lm), 8'd12);
    chk("modeinc_hours", 8'(last_lh), 8'd5);

    // Random button activity against the model.
    for (int it = 0; it < 250; it++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        reset_pulse();
      end else begin
        if (r < 4) begin
          cur_hours   = 6'($urandom_range(0, 23));
          cur_minutes = 6'($urandom_range(0, 59));
        end
        btn_mode_n = ($urandom_range(0, 3) != 0);
        btn_inc_n  = ($urandom_range(0, 2) != 0);
        btn_dec_n  = ($urandom_range(0, 2) != 0);
        hold = int'($urandom_range(1, 9));
        repeat (hold) cycle();
      end
    end
    btn_mode_n = 1; btn_inc_n = 1; btn_dec_n = 1;
    repeat (10) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
